// File: rtl/mem_io_responder_pkg.sv
// Shared address map and access decode for the CPU byte-bus responder.
package mem_io_responder_pkg;

    // Memory-mapped IO locations (18-bit decoded address space)
    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
    localparam logic [1:0]  IO_SEL       = 2'b11;

    // Kind of bus access selected by the current address
    typedef enum logic [2:0] {
        ACC_RAM     = 3'd0,   // plain byte RAM
        ACC_UART    = 3'd1,   // 0x30000: tx push on write, rx pop on read
        ACC_CLK     = 3'd2,   // 0x30004: snapshot latch on read, stop on write
        ACC_SNAP    = 3'd3,   // 0x30005..7: upper snapshot bytes
        ACC_IO_NONE = 3'd4    // any other IO address: reads 0, writes ignored
    } acc_e;

    function automatic acc_e decode_addr(input logic [17:0] a);
        if (a[17:16] != IO_SEL) begin
            return ACC_RAM;
        end
        if (a == IO_UART_ADDR) begin
            return ACC_UART;
        end
        if (a == IO_CLK_ADDR) begin
            return ACC_CLK;
        end
        if (a[17:2] == IO_CLK_ADDR[17:2]) begin
            return ACC_SNAP;
        end
        return ACC_IO_NONE;
    endfunction

    // Little-endian byte k of a 32-bit word
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        return w[8*k +: 8];
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// First-word-fall-through byte FIFO used for the UART tx and rx queues.
// A push while full is accepted when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH_LG = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [7:0]        din_i,
    output logic [7:0]        dout_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [DEPTH_LG:0] count_o
);

    localparam int DEPTH = 1 << DEPTH_LG;
    localparam logic [DEPTH_LG:0] FULL_CNT = (DEPTH_LG + 1)'(DEPTH);

    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LG:0]   count_q, count_d;
    logic                do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LG'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LG'(1);
        end
        count_d = count_q + (DEPTH_LG + 1)'(do_push) - (DEPTH_LG + 1)'(do_pop);
    end

    // Control state: reset empties the queue
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage: written only on accepted pushes outside reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Target end of the CPU byte bus: byte RAM with a one-cycle registered read,
// plus UART tx/rx queues, a free-running cycle counter with read snapshot,
// and a program-stop port in the 0x3xxxx IO window.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int    RAM_AW      = 17,
    parameter int    TX_DEPTH_LG = 4,
    parameter int    RX_DEPTH_LG = 4,
    parameter int    FULL_MARGIN = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_mem_a,
    input  logic [7:0]  cpu_mem_dout,
    input  logic        cpu_mem_wr,
    output logic [7:0]  cpu_mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LG;
    localparam logic [TX_DEPTH_LG:0] TX_FULL_AT = (TX_DEPTH_LG + 1)'(TX_DEPTH - FULL_MARGIN);

    acc_e              acc;
    logic [RAM_AW-1:0] ram_idx;
    logic              rd_cyc, wr_cyc;
    logic              unused_hi;

    assign acc       = decode_addr(cpu_mem_a[17:0]);
    assign ram_idx   = cpu_mem_a[RAM_AW-1:0];
    assign rd_cyc    = !rst_in && !cpu_mem_wr;
    assign wr_cyc    = !rst_in && cpu_mem_wr;
    assign unused_hi = ^cpu_mem_a[31:18];

    // ------------------------------------------------------------------
    // Byte RAM
    // ------------------------------------------------------------------
    logic [7:0] ram_q [2**RAM_AW];
    logic [7:0] ram_rd_q;
    logic       ram_we, ram_re;

    assign ram_we = wr_cyc && (acc == ACC_RAM);
    assign ram_re = rd_cyc && (acc == ACC_RAM);

    // Single-port RAM; the read register holds on non-read cycles so the
    // returned byte survives following write cycles
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram_q[ram_idx] <= cpu_mem_dout;
        end
        if (ram_re) begin
            ram_rd_q <= ram_q[ram_idx];
        end
    end

    // ------------------------------------------------------------------
    // UART queues
    // ------------------------------------------------------------------
    logic                 tx_empty, tx_full, tx_wr, tx_pop, tx_push_acc;
    logic [TX_DEPTH_LG:0] tx_count, tx_cnt_nxt;

    assign tx_valid    = !tx_empty;
    assign tx_pop      = !rst_in && tx_valid && tx_ready;
    // 0x00 is treated as "no character" and never enqueued
    assign tx_wr       = wr_cyc && (acc == ACC_UART) && (cpu_mem_dout != 8'h00);
    assign tx_push_acc = tx_wr && (!tx_full || tx_pop);
    assign tx_cnt_nxt  = tx_count + (TX_DEPTH_LG + 1)'(tx_push_acc) - (TX_DEPTH_LG + 1)'(tx_pop);

    byte_fifo #(
        .DEPTH_LG (TX_DEPTH_LG)
    ) u_tx_fifo (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .push_i   (tx_wr),
        .pop_i    (tx_pop),
        .din_i    (cpu_mem_dout),
        .dout_o   (tx_data),
        .full_o   (tx_full),
        .empty_o  (tx_empty),
        .count_o  (tx_count)
    );

    logic                 rx_empty, rx_full, rx_pop;
    logic [7:0]           rx_dout;
    logic [RX_DEPTH_LG:0] rx_count_unused;

    assign rx_ready = !rx_full;
    assign rx_pop   = rd_cyc && (acc == ACC_UART) && !rx_empty;

    byte_fifo #(
        .DEPTH_LG (RX_DEPTH_LG)
    ) u_rx_fifo (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .push_i   (rx_valid && rx_ready),
        .pop_i    (rx_pop),
        .din_i    (rx_data),
        .dout_o   (rx_dout),
        .full_o   (rx_full),
        .empty_o  (rx_empty),
        .count_o  (rx_count_unused)
    );

    // ------------------------------------------------------------------
    // IO read path, counter and status
    // ------------------------------------------------------------------
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic [7:0]  io_rd_q, io_rd_d;
    logic        sel_ram_q, sel_ram_d;
    logic        stop_req_q, stop_req_d;
    logic        prog_stop_q, prog_stop_d;
    logic        ovf_q, ovf_d;
    logic        ibf_q, ibf_d;

    // Next-state for read-data source, snapshot, counter and sticky flags
    always_comb begin
        io_rd_d   = io_rd_q;
        sel_ram_d = sel_ram_q;
        snap_d    = snap_q;
        if (rd_cyc) begin
            sel_ram_d = (acc == ACC_RAM);
            unique case (acc)
                ACC_UART: io_rd_d = rx_empty ? 8'h00 : rx_dout;
                ACC_CLK: begin
                    // Byte 0 comes from the live counter so it matches the snapshot
                    io_rd_d = cnt_q[7:0];
                    snap_d  = cnt_q;
                end
                ACC_SNAP: io_rd_d = word_byte(snap_q, cpu_mem_a[1:0]);
                default:  io_rd_d = 8'h00;
            endcase
        end
        cnt_d       = cnt_q + 32'd1;
        stop_req_d  = stop_req_q || (wr_cyc && (acc == ACC_CLK));
        prog_stop_d = prog_stop_q || (stop_req_q && tx_empty);
        ovf_d       = ovf_q || (tx_wr && tx_full && !tx_pop);
        // Judged on next occupancy so the cpu sees it in time to hold its next write
        ibf_d       = (tx_cnt_nxt >= TX_FULL_AT);
    end

    // Register update with synchronous reset of all control state
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            io_rd_q     <= 8'h00;
            sel_ram_q   <= 1'b0;
            snap_q      <= '0;
            cnt_q       <= '0;
            stop_req_q  <= 1'b0;
            prog_stop_q <= 1'b0;
            ovf_q       <= 1'b0;
            ibf_q       <= 1'b0;
        end else begin
            io_rd_q     <= io_rd_d;
            sel_ram_q   <= sel_ram_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            stop_req_q  <= stop_req_d;
            prog_stop_q <= prog_stop_d;
            ovf_q       <= ovf_d;
            ibf_q       <= ibf_d;
        end
    end

    assign cpu_mem_din    = sel_ram_q ? ram_rd_q : io_rd_q;
    assign program_stop   = prog_stop_q;
    assign tx_overflow    = ovf_q;
    assign io_buffer_full = ibf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized bench for mem_io_responder with a queue-based reference model
// and a scoreboard monitor sampling on the falling edge.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_mem_a;
    logic [7:0]  cpu_mem_dout;
    logic        cpu_mem_wr;
    logic [7:0]  cpu_mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    always #5 clk_in = ~clk_in;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_mem_a      (cpu_mem_a),
        .cpu_mem_dout   (cpu_mem_dout),
        .cpu_mem_wr     (cpu_mem_wr),
        .cpu_mem_din    (cpu_mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    // Reference model state
    logic [7:0]  ram_m [int];
    logic [7:0]  txq [$];
    logic [7:0]  rxq [$];
    logic [7:0]  exp_tx_q [$];
    logic [7:0]  exp_din_q [$];
    int unsigned cnt_m, snap_m;
    logic [7:0]  din_m;
    bit          stop_m, pstop_m, ovf_m, ibf_m;
    bit          started = 0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] pool [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock of bus behaviour, evaluated from the stimulus at the edge
    task automatic model_step();
        logic [17:0] a;
        bit          io, txpop;
        int          rx_pre, k;
        started = 1;
        a = cpu_mem_a[17:0];
        if (rst_in) begin
            txq.delete();
            rxq.delete();
            exp_tx_q.delete();
            cnt_m = 0; snap_m = 0; din_m = 8'h00;
            stop_m = 0; pstop_m = 0; ovf_m = 0; ibf_m = 0;
            exp_din_q.push_back(din_m);
            return;
        end
        io     = (a >= 18'h30000);
        txpop  = tx_ready && (txq.size() > 0);
        rx_pre = rxq.size();
        pstop_m = pstop_m || (stop_m && txq.size() == 0);
        if (!cpu_mem_wr) begin
            if (!io) begin
                din_m = ram_m.exists(int'(a[16:0])) ? ram_m[int'(a[16:0])] : 8'h00;
            end else if (a == 18'h30000) begin
                din_m = (rx_pre > 0) ? rxq.pop_front() : 8'h00;
            end else if (a == 18'h30004) begin
                snap_m = cnt_m;
                din_m  = 8'(cnt_m);
            end else if (a >= 18'h30005 && a <= 18'h30007) begin
                k = int'(a) - 'h30004;
                din_m = 8'(snap_m >> (8 * k));
            end else begin
                din_m = 8'h00;
            end
        end
        if (txpop) void'(txq.pop_front());
        if (cpu_mem_wr) begin
            if (!io) begin
                ram_m[int'(a[16:0])] = cpu_mem_dout;
            end else if (a == 18'h30000 && cpu_mem_dout != 8'h00) begin
                if (txq.size() < 16) begin
                    txq.push_back(cpu_mem_dout);
                    exp_tx_q.push_back(cpu_mem_dout);
                end else begin
                    ovf_m = 1;
                end
            end else if (a == 18'h30004) begin
                stop_m = 1;
            end
        end
        if (rx_valid && rx_pre < 16) rxq.push_back(rx_data);
        ibf_m = ((16 - txq.size()) <= 2);
        cnt_m++;
        exp_din_q.push_back(din_m);
    endtask

    // Scoreboard monitor
    always @(negedge clk_in) begin
        if (started) begin
            if (exp_din_q.size() > 0) chk("cpu_mem_din", cpu_mem_din, exp_din_q.pop_front());
            chk("io_buffer_full", io_buffer_full, ibf_m);
            chk("tx_overflow", tx_overflow, ovf_m);
            chk("program_stop", program_stop, pstop_m);
            chk("tx_valid", tx_valid, txq.size() > 0);
            chk("rx_ready", rx_ready, rxq.size() < 16);
            if (!rst_in && tx_valid && tx_ready) begin
                if (exp_tx_q.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else chk("tx_data", tx_data, exp_tx_q.pop_front());
            end
        end
    end

    task automatic drive(input logic rst, input logic [31:0] a, input logic wr, input logic [7:0] d);
        rst_in = rst; cpu_mem_a = a; cpu_mem_wr = wr; cpu_mem_dout = d;
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic        rst;
        int          sel;

        rst_in = 1'b1; cpu_mem_a = '0; cpu_mem_wr = 1'b0; cpu_mem_dout = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;

        // Reset with a UART write pending: must be ignored
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h30000, 1'b1, 8'h55);

        // Initialise RAM locations used by the bench
        drive(1'b0, 32'h0, 1'b1, 8'h00);
        pool[0] = 18'h00010;
        pool[1] = 18'h1FFFF;
        for (int i = 2; i < 16; i++) pool[i] = 18'($urandom_range(0, 'h2FFFF));
        for (int i = 0; i < 16; i++) drive(1'b0, {14'($urandom), pool[i]}, 1'b1, 8'($urandom));

        // Write then read the same address on the next cycle
        drive(1'b0, 32'h00010, 1'b1, 8'hA5);
        drive(1'b0, 32'h00010, 1'b0, 8'h00);
        drive(1'b0, 32'h00020, 1'b1, 8'h3C);   // write cycle must hold din
        idle(1);

        // Counter snapshot taken at cycle 100 after reset release
        while (cnt_m < 100) idle(1);
        drive(1'b0, 32'h30004, 1'b0, 8'h00);
        for (int k = 5; k < 8; k++) begin
            idle($urandom_range(0, 4));
            drive(1'b0, 32'h30000 + k, 1'b0, 8'h00);
        end

        // Two received bytes then three UART reads
        rx_valid = 1'b1; rx_data = 8'h41; idle(1);
        rx_data = 8'h42; idle(1);
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h30000, 1'b0, 8'h00);

        // Fill the tx queue with the transmitter stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) drive(1'b0, 32'h30000, 1'b1, 8'(i + 1));
        drive(1'b0, 32'h30000, 1'b1, 8'h00);
        tx_ready = 1'b1;
        idle(20);

        // Stop request while three bytes are still queued
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h30000, 1'b1, 8'h60 + 8'(i));
        drive(1'b0, 32'h30004, 1'b1, 8'h01);
        idle(2);
        tx_ready = 1'b1;
        idle(6);

        // Reset mid-stream with a UART write on the bus; RAM must survive
        tx_ready = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h7E; idle(3);
        rx_valid = 1'b0;
        drive(1'b0, 32'h30000, 1'b1, 8'h11);
        drive(1'b0, 32'h30000, 1'b1, 8'h22);
        drive(1'b1, 32'h30000, 1'b1, 8'h77);
        drive(1'b1, 32'h30000, 1'b1, 8'h78);
        tx_ready = 1'b1;
        drive(1'b0, 32'h30000, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) drive(1'b0, {14'h0, pool[i]}, 1'b0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            tx_ready = ($urandom_range(0, 3) != 0);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            d  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            a  = $urandom;
            wr = 1'($urandom);
            if (sel < 40) begin
                a[17:0] = pool[$urandom_range(0, 15)];
            end else if (sel < 70) begin
                a[17:0] = 18'h30000;
            end else if (sel < 85) begin
                a[17:0] = 18'h30004 + 18'($urandom_range(0, 3));
                wr = 1'b0;
            end else if (sel < 87) begin
                a[17:0] = 18'h30004;
                wr = 1'b1;
            end else if (sel < 95) begin
                a[17:0] = 18'h30008 + 18'($urandom_range(0, 'hFFF0));
            end else begin
                a[17:0] = 18'h30000 + 18'($urandom_range(1, 3));
            end
            rst = ($urandom_range(0, 499) == 0);
            drive(rst, a, wr, d);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
